// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//
// Shares one pipelined sprite ROM among NUM_REQ requesters.
//
// Arbitration is round-robin and can issue one grant per cycle. The grant
// (gnt) is combinational from req and the registered pointer rr_ptr_q. The
// granted requester's address is forwarded to rom_addr in the same cycle.
//
// A tag pipeline of ROM_LATENCY stages records which requester was granted.
// When the tag leaves the last stage, the block raises rsp_valid for that
// requester, in the same cycle that the ROM presents the word.
//
// Handshake: a requester raises req with req_addr and holds both stable
// until it sees gnt high in a cycle; that cycle is the transfer. It may
// drop or change req/req_addr from the next cycle on. A req left high is
// simply arbitrated again.
//
// Optional feature macro: SPRITE_ARB_PRIO0_EN. When it is defined,
// requester 0 has strict priority. The pointer then rotates only among
// requesters 1..NUM_REQ-1, and a grant to requester 0 does not move it.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int ROM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_dout,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic                               gnt_vld;
  logic [IDX_W-1:0]                   gnt_idx;
  logic [IDX_W-1:0]                   cand;
  logic                               ptr_adv;
  logic [ROM_LATENCY-1:0]             tag_vld_q, tag_vld_d;
  logic [ROM_LATENCY-1:0][IDX_W-1:0]  tag_idx_q, tag_idx_d;

  // Winner search: start at rr_ptr_q, wrap modulo NUM_REQ, and take the
  // first requester whose req is high. Reset forces "no grant".
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
`ifdef SPRITE_ARB_PRIO0_EN
    if (req[0]) begin
      gnt_vld = 1'b1;
    end
`endif
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!reset_n) begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
    end
  end

  // Decode the winner: one-hot grant, and the winner's address slice.
  always_comb begin
    gnt      = '0;
    rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == IDX_W'(i))) begin
        gnt[i]   = 1'b1;
        rom_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Pointer moves to the requester after the winner. It holds when nothing
  // is granted, and also on a priority grant to requester 0.
  always_comb begin
    ptr_adv  = gnt_vld;
`ifdef SPRITE_ARB_PRIO0_EN
    ptr_adv  = gnt_vld && (gnt_idx != '0);
`endif
    rr_ptr_d = rr_ptr_q;
    if (ptr_adv) begin
      rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Tag pipeline: stage 0 takes this cycle's grant, and every stage
  // shifts by one each cycle.
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = gnt_vld;
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < ROM_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  // State registers. Reset discards in-flight reads and rewinds the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  // Response: the last tag stage lines up with the word now on rom_dout.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_vld_q[ROM_LATENCY-1] &&
                     (tag_idx_q[ROM_LATENCY-1] == IDX_W'(i));
    end
  end

  assign rsp_data = rom_dout;
  assign busy     = |tag_vld_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter.
//
// Two instances share the same requester inputs. dut_l2 uses
// ROM_LATENCY=2 and dut_l1 uses ROM_LATENCY=1. Each instance has its own
// small ROM model, a pipeline of matching depth.
//
// The reference model keeps a plain integer round-robin pointer. For each
// latency it also keeps a per-cycle queue of expected responses.
//
// SPRITE_ARB_PRIO0_EN selects the priority variant, in the model and in
// the directed sequence.
module tb_sprite_rom_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int EW = NR + DW;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;

  logic [NR-1:0]     gnt2, gnt1;
  logic [AW-1:0]     rom_addr2, rom_addr1;
  logic [DW-1:0]     rom_dout2, rom_dout1;
  logic [NR-1:0]     rsp_valid2, rsp_valid1;
  logic [DW-1:0]     rsp_data2, rsp_data1;
  logic              busy2, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(2)) dut_l2 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt2), .rom_addr(rom_addr2), .rom_dout(rom_dout2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .busy(busy2));

  sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .gnt(gnt1), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1));

  // ---------------- ROM models ----------------
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (a == 8'h2A) return 16'hBEEF;
    return {a ^ 8'h5A, ~a};
  endfunction

  logic [AW-1:0] p2_0, p2_1, p1_0;
  always @(posedge clk) begin
    p2_0 <= rom_addr2;
    p2_1 <= p2_0;
    p1_0 <= rom_addr1;
  end
  assign rom_dout2 = rom_word(p2_1);
  assign rom_dout1 = rom_word(p1_0);

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model + compare ----------------
  logic [EW-1:0] exp_q2[$];
  logic [EW-1:0] exp_q1[$];
  int            m_ptr = 0;
  int            g_idx;
  int            c_idx;
  logic [NR-1:0] exp_g;
  logic [AW-1:0] exp_a;
  logic          busy_e;
  logic [EW-1:0] ent;

  initial begin
    forever begin
      @(negedge clk);
      // expected arbitration result for this cycle
      g_idx = -1;
      exp_g = '0;
      exp_a = '0;
      if (reset_n) begin
`ifdef SPRITE_ARB_PRIO0_EN
        if (req[0]) g_idx = 0;
`endif
        for (int k = 0; k < NR; k++) begin
          c_idx = (m_ptr + k) % NR;
          if (g_idx < 0 && req[c_idx]) g_idx = c_idx;
        end
      end
      if (g_idx >= 0) begin
        exp_g[g_idx] = 1'b1;
        exp_a = req_addr[g_idx*AW +: AW];
      end
      chk("gnt_l2", gnt2, exp_g);
      chk("gnt_l1", gnt1, exp_g);
      chk("rom_addr_l2", rom_addr2, exp_a);
      chk("rom_addr_l1", rom_addr1, exp_a);

      // reset empties the read pipeline
      if (!reset_n) begin
        exp_q2.delete();
        exp_q2.push_back('0);
        exp_q2.push_back('0);
        exp_q1.delete();
        exp_q1.push_back('0);
      end

      // latency 2: the queue holds the grants of cycles c-2 and c-1
      busy_e = 1'b0;
      foreach (exp_q2[k]) busy_e = busy_e | (|exp_q2[k][EW-1:DW]);
      ent = exp_q2.pop_front();
      chk("rsp_valid_l2", rsp_valid2, ent[EW-1:DW]);
      if (ent[EW-1:DW] != '0) chk("rsp_data_l2", rsp_data2, ent[DW-1:0]);
      chk("busy_l2", busy2, busy_e);
      exp_q2.push_back({exp_g, rom_word(exp_a)});

      // latency 1: the queue holds the grant of cycle c-1
      busy_e = 1'b0;
      foreach (exp_q1[k]) busy_e = busy_e | (|exp_q1[k][EW-1:DW]);
      ent = exp_q1.pop_front();
      chk("rsp_valid_l1", rsp_valid1, ent[EW-1:DW]);
      if (ent[EW-1:DW] != '0) chk("rsp_data_l1", rsp_data1, ent[DW-1:0]);
      chk("busy_l1", busy1, busy_e);
      exp_q1.push_back({exp_g, rom_word(exp_a)});

      // pointer for the next cycle
      if (!reset_n) begin
        m_ptr = 0;
      end else if (g_idx >= 0) begin
`ifdef SPRITE_ARB_PRIO0_EN
        if (g_idx != 0) m_ptr = (g_idx + 1) % NR;
`else
        m_ptr = (g_idx + 1) % NR;
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      req = '0;
    end
  endtask

  logic [NR-1:0] vec [24];
  logic [AW-1:0] a0, a1, a2;

  // ---------------- stimulus ----------------
  initial begin
    vec = '{3'b111, 3'b101, 3'b011, 3'b110, 3'b000, 3'b001, 3'b111, 3'b111,
            3'b100, 3'b010, 3'b011, 3'b101, 3'b000, 3'b110, 3'b111, 3'b001,
            3'b001, 3'b010, 3'b100, 3'b111, 3'b011, 3'b000, 3'b101, 3'b110};
    reset_n  = 1'b0;
    req      = 3'b111;
    req_addr = {8'h12, 8'h11, 8'h10};

    // reset holds everything quiet regardless of req
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt2, 3'b000);
    chk("rst_rom_addr", rom_addr2, 8'h00);
    chk("rst_rsp_valid", rsp_valid2, 3'b000);
    chk("rst_busy", busy2, 1'b0);

`ifdef SPRITE_ARB_PRIO0_EN
    next_cycle(); reset_n = 1'b1;
    @(negedge clk); chk("p0_gnt_a", gnt2, 3'b001);
    next_cycle();
    @(negedge clk); chk("p0_gnt_b", gnt2, 3'b001);
    next_cycle();
    @(negedge clk); chk("p0_gnt_c", gnt2, 3'b001);
    next_cycle(); req = 3'b110;
    @(negedge clk); chk("p0_alt_a", gnt2, 3'b010);
    next_cycle();
    @(negedge clk); chk("p0_alt_b", gnt2, 3'b100);
    next_cycle();
    @(negedge clk); chk("p0_alt_c", gnt2, 3'b010);
    idle(3);
`else
    // all requesting: grants rotate 0,1,2,0
    next_cycle(); reset_n = 1'b1;
    @(negedge clk);
    chk("rr_gnt_a", gnt2, 3'b001);
    chk("rr_addr_a", rom_addr2, 8'h10);
    next_cycle();
    @(negedge clk);
    chk("rr_gnt_b", gnt2, 3'b010);
    chk("rr_addr_b", rom_addr2, 8'h11);
    chk("rr_rsp1_a", rsp_valid1, 3'b001);
    next_cycle();
    @(negedge clk);
    chk("rr_gnt_c", gnt2, 3'b100);
    chk("rr_rsp2_a", rsp_valid2, 3'b001);
    chk("rr_rsp1_b", rsp_valid1, 3'b010);
    next_cycle();
    @(negedge clk);
    chk("rr_gnt_d", gnt2, 3'b001);
    chk("rr_rsp2_b", rsp_valid2, 3'b010);

    // ten idle cycles; the pointer must still sit at requester 1
    idle(10);
    @(negedge clk);
    chk("idle_gnt", gnt2, 3'b000);
    chk("idle_addr", rom_addr2, 8'h00);
    chk("idle_busy", busy2, 1'b0);
    next_cycle(); req = 3'b111;
    @(negedge clk); chk("idle_ptr_kept", gnt2, 3'b010);
    idle(3);

    // single read of word 0x2A by requester 1
    next_cycle(); req = 3'b010; req_addr = {8'h12, 8'h2A, 8'h10};
    @(negedge clk);
    chk("one_gnt", gnt2, 3'b010);
    chk("one_addr", rom_addr2, 8'h2A);
    next_cycle(); req = '0;
    @(negedge clk);
    chk("one_busy_1", busy2, 1'b1);
    chk("one_rsp_early", rsp_valid2, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("one_rsp", rsp_valid2, 3'b010);
    chk("one_data", rsp_data2, 16'hBEEF);
    chk("one_busy_2", busy2, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("one_busy_off", busy2, 1'b0);

    // back-to-back grants 2 then 0, checked on the latency-1 instance
    next_cycle(); req = 3'b100; req_addr = {8'h12, 8'h11, 8'h10};
    @(negedge clk); chk("b2b_gnt_2", gnt1, 3'b100);
    next_cycle(); req = 3'b001;
    @(negedge clk);
    chk("b2b_gnt_0", gnt1, 3'b001);
    chk("b2b_rsp_2", rsp_valid1, 3'b100);
    next_cycle(); req = '0;
    @(negedge clk);
    chk("b2b_rsp_0", rsp_valid1, 3'b001);
    chk("b2b_data_0", rsp_data1, 16'h4AEF);
    chk("b2b_l2_rsp_2", rsp_valid2, 3'b100);

    // grant, then reset on the next cycle: that read never returns
    next_cycle(); req = 3'b010;
    @(negedge clk); chk("rst_mid_gnt", gnt2, 3'b010);
    next_cycle(); req = '0; reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rsp_l1", rsp_valid1, 3'b000);
    chk("rst_mid_busy", busy2, 1'b0);
    next_cycle();
    @(negedge clk); chk("rst_mid_rsp_l2", rsp_valid2, 3'b000);
    next_cycle(); reset_n = 1'b1;
    @(negedge clk); chk("rst_mid_after", rsp_valid2, 3'b000);
    next_cycle(); req = 3'b111;
    @(negedge clk); chk("rst_mid_ptr0", gnt2, 3'b001);
    idle(1);
`endif

    // directed sweep, checked by the model every cycle
    for (int i = 0; i < 24; i++) begin
      next_cycle();
      a0 = 8'(i * 7);
      a1 = 8'(i * 5 + 1);
      a2 = 8'(i * 3 + 2);
      req      = vec[i];
      req_addr = {a2, a1, a0};
    end
    idle(4);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
